// File: rtl/boss_danmaku_if.sv
// boss_danmaku_if: boss/player positions in, bullet pool and player status out.
interface boss_danmaku_if;
    logic        boss;
    logic [9:0]  bossx, bossy, reimux, reimuy;
    logic [79:0] bullet_x, bullet_y;
    logic [7:0]  bullet_v;
    logic [1:0]  lives;
    logic        hit, invuln, gameover;
    modport master (output boss, bossx, bossy, reimux, reimuy,
                    input  bullet_x, bullet_y, bullet_v, lives, hit, invuln, gameover);
    modport slave  (input  boss, bossx, bossy, reimux, reimuy,
                    output bullet_x, bullet_y, bullet_v, lives, hit, invuln, gameover);
endinterface

// File: rtl/boss_danmaku.sv
// boss_danmaku: spawns boss bullets into an 8-slot pool, moves them each tick,
// detects hits on Reimu and owns lives / invulnerability / gameover.
module boss_danmaku #(
    parameter int SPAWN_PERIOD = 16,
    parameter int SPEED        = 4,
    parameter int HIT_R        = 8,
    parameter int LIVES        = 3,
    parameter int INV_TICKS    = 64
) (
    input logic           clk22,
    input logic           rst,
    boss_danmaku_if.slave bus
);
    localparam int CW = $clog2(SPAWN_PERIOD + 1);
    localparam int IW = $clog2(INV_TICKS + 1);

    logic [7:0][9:0] bx_q, bx_d, by_q, by_d;
    logic [7:0][2:0] bd_q, bd_d;
    logic [7:0]      bv_q, bv_d, hits;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   inv_q, inv_d;
    logic [2:0]      dir_q, dir_d, slot;
    logic [1:0]      lives_q, lives_d;
    logic            hit_q, hit_d, go_q, go_d, found, run;
    logic signed [10:0] ex, ey, nx, ny;
    logic [10:0]     ax, ay;

    // dy of direction d equals dx of direction d+2
    function automatic logic signed [10:0] step(input logic [2:0] d);
        return (d[1:0] == 2'd0) ? 11'sd0 : d[2] ? -$signed(11'(SPEED)) : $signed(11'(SPEED));
    endfunction

    assign run = !go_q;

    always_comb begin
        hits = '0;
        ex = '0;
        ey = '0;
        ax = '0;
        ay = '0;
        for (int i = 0; i < 8; i++) begin
            ex = $signed({1'b0, bx_q[i]}) - $signed({1'b0, bus.reimux});
            ey = $signed({1'b0, by_q[i]}) - $signed({1'b0, bus.reimuy});
            ax = ex[10] ? -ex : ex;
            ay = ey[10] ? -ey : ey;
            hits[i] = run && inv_q == '0 && bv_q[i] && ax < 11'(HIT_R) && ay < 11'(HIT_R);
        end
    end

    always_comb begin
        found = 1'b0;
        slot = '0;
        for (int i = 7; i >= 0; i--)
            if (!bv_q[i]) begin
                found = 1'b1;
                slot = 3'(i);
            end
    end

    always_comb begin
        bx_d = bx_q;
        by_d = by_q;
        bd_d = bd_q;
        bv_d = bv_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        inv_d = inv_q;
        lives_d = lives_q;
        hit_d = 1'b0;
        go_d = go_q;
        nx = '0;
        ny = '0;
        if (run) begin
            for (int i = 0; i < 8; i++) begin
                nx = $signed({1'b0, bx_q[i]}) + step(bd_q[i]);
                ny = $signed({1'b0, by_q[i]}) + step(bd_q[i] + 3'd2);
                if (bv_q[i]) begin
                    if (hits[i] || nx[10] || nx > 11'sd639 || ny[10] || ny > 11'sd479)
                        bv_d[i] = 1'b0;
                    else begin
                        bx_d[i] = nx[9:0];
                        by_d[i] = ny[9:0];
                    end
                end
            end
            // the spawn target was free before this edge, so it never collides with a move
            if (bus.boss) begin
                if (cnt_q == CW'(SPAWN_PERIOD - 1)) begin
                    cnt_d = '0;
                    if (found && bus.bossy <= 10'd463) begin
                        bx_d[slot] = bus.bossx;
                        by_d[slot] = bus.bossy + 10'd16;
                        bd_d[slot] = dir_q;
                        bv_d[slot] = 1'b1;
                        dir_d = dir_q + 3'd1;
                    end
                end else
                    cnt_d = cnt_q + 1'b1;
            end
            inv_d = |hits ? IW'(INV_TICKS) : inv_q != '0 ? inv_q - 1'b1 : inv_q;
            if (|hits) begin
                lives_d = lives_q - 2'd1;
                hit_d = 1'b1;
                go_d = lives_q == 2'd1;
            end
        end
        if (!bus.boss) cnt_d = '0;
    end

    always_ff @(posedge clk22 or negedge rst) begin
        if (!rst) begin
            bx_q <= '0;
            by_q <= '0;
            bd_q <= '0;
            bv_q <= '0;
            cnt_q <= '0;
            dir_q <= '0;
            inv_q <= '0;
            lives_q <= 2'(LIVES);
            hit_q <= 1'b0;
            go_q <= 1'b0;
        end else begin
            bx_q <= bx_d;
            by_q <= by_d;
            bd_q <= bd_d;
            bv_q <= bv_d;
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            inv_q <= inv_d;
            lives_q <= lives_d;
            hit_q <= hit_d;
            go_q <= go_d;
        end
    end

    assign bus.bullet_x = bx_q;
    assign bus.bullet_y = by_q;
    assign bus.bullet_v = bv_q;
    assign bus.lives    = lives_q;
    assign bus.hit      = hit_q;
    assign bus.invuln   = inv_q != '0;
    assign bus.gameover = go_q;
endmodule

// File: tb/tb_boss_danmaku.sv
// tb_boss_danmaku: directed scenarios checked against an integer pool model every cycle.
module tb_boss_danmaku;
    localparam int SP = 16, SPD = 4, HR = 8, NL = 3, INV = 64;

    logic clk22 = 1'b0;
    logic rst;
    int nvec = 0, nerr = 0, e = 0;
    int mx[8], my[8], mv[8], md[8];
    int mlives, minv, mgo, mcnt, mdir, mhit;
    int tdx[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int tdy[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
    int bxt[11] = '{320, 320, 0, 0, 320, 639, 639, 639, 320, 0, 320};
    int byt[11] = '{463, 463, 200, 463, 463, 463, 200, 0, 0, 0, 200};

    boss_danmaku_if ifc ();
    boss_danmaku dut (.clk22(clk22), .rst(rst), .bus(ifc.slave));

    always #5 clk22 = ~clk22;

    function automatic int iabs(input int a);
        return a < 0 ? -a : a;
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mx[i] = 0; my[i] = 0; mv[i] = 0; md[i] = 0;
        end
        mlives = NL; minv = 0; mgo = 0; mcnt = 0; mdir = 0; mhit = 0;
    endtask

    task automatic model_step();
        int ov[8];
        bit h[8];
        int fr, nx, ny, any, rx, ry, bx, by;
        rx = int'(ifc.reimux); ry = int'(ifc.reimuy);
        bx = int'(ifc.bossx); by = int'(ifc.bossy);
        mhit = 0;
        if (mgo == 0) begin
            fr = -1; any = 0;
            for (int i = 0; i < 8; i++) begin
                ov[i] = mv[i];
                if (mv[i] == 0 && fr < 0) fr = i;
                h[i] = mv[i] != 0 && minv == 0 && iabs(mx[i] - rx) < HR && iabs(my[i] - ry) < HR;
                if (h[i]) any = 1;
            end
            for (int i = 0; i < 8; i++)
                if (ov[i] != 0) begin
                    nx = mx[i] + SPD * tdx[md[i]];
                    ny = my[i] + SPD * tdy[md[i]];
                    if (h[i] || nx < 0 || nx > 639 || ny < 0 || ny > 479) mv[i] = 0;
                    else begin mx[i] = nx; my[i] = ny; end
                end
            if (ifc.boss) begin
                if (mcnt == SP - 1) begin
                    mcnt = 0;
                    if (fr >= 0 && by <= 463) begin
                        mx[fr] = bx; my[fr] = by + 16; md[fr] = mdir; mv[fr] = 1;
                        mdir = (mdir + 1) % 8;
                    end
                end else mcnt++;
            end
            if (any != 0) begin
                minv = INV; mlives--; mhit = 1;
                if (mlives == 0) mgo = 1;
            end else if (minv > 0) minv--;
        end
        if (!ifc.boss) mcnt = 0;
    endtask

    always @(posedge clk22 or negedge rst)
        if (!rst) model_reset();
        else model_step();

    always @(negedge clk22)
        if (rst === 1'b1) begin
            logic [79:0] ex, ey;
            logic [7:0] ev;
            for (int i = 0; i < 8; i++) begin
                ex[10*i +: 10] = 10'(mx[i]);
                ey[10*i +: 10] = 10'(my[i]);
                ev[i] = mv[i] != 0;
            end
            chk("bullet_x", ifc.bullet_x, ex);
            chk("bullet_y", ifc.bullet_y, ey);
            chk("bullet_v", 80'(ifc.bullet_v), 80'(ev));
            chk("lives", 80'(ifc.lives), 80'(mlives));
            chk("hit", 80'(ifc.hit), 80'(mhit));
            chk("invuln", 80'(ifc.invuln), 80'(minv != 0));
            chk("gameover", 80'(ifc.gameover), 80'(mgo));
        end

    task automatic go_to(input int t);
        while (e < t) begin
            @(posedge clk22);
            #1;
            e++;
        end
    endtask

    task automatic set_boss(input int x, input int y);
        ifc.bossx = 10'(x); ifc.bossy = 10'(y);
    endtask

    task automatic set_reimu(input int x, input int y);
        ifc.reimux = 10'(x); ifc.reimuy = 10'(y);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_v"}, 80'(ifc.bullet_v), 80'd0);
        chk({tag, "_x"}, ifc.bullet_x, 80'd0);
        chk({tag, "_y"}, ifc.bullet_y, 80'd0);
        chk({tag, "_lives"}, 80'(ifc.lives), 80'd3);
        chk({tag, "_hit"}, 80'(ifc.hit), 80'd0);
        chk({tag, "_invuln"}, 80'(ifc.invuln), 80'd0);
        chk({tag, "_gameover"}, 80'(ifc.gameover), 80'd0);
    endtask

    initial begin
        rst = 1'b0;
        ifc.boss = 1'b0;
        set_boss(320, 100);
        set_reimu(320, 470);
        repeat (2) @(posedge clk22);
        #1;
        chk_reset("rst0");
        rst = 1'b1; ifc.boss = 1'b1; e = 0;
        go_to(16);
        chk("spawn_v0", 80'(ifc.bullet_v[0]), 80'd1);
        chk("spawn_x0", 80'(ifc.bullet_x[9:0]), 80'd320);
        chk("spawn_y0", 80'(ifc.bullet_y[9:0]), 80'd116);
        go_to(17);
        chk("move_x0", 80'(ifc.bullet_x[9:0]), 80'd320);
        chk("move_y0", 80'(ifc.bullet_y[9:0]), 80'd120);
        set_reimu(0, 0);
        go_to(20); set_reimu(312, 139);
        go_to(21);
        chk("edge8_hit", 80'(ifc.hit), 80'd0);
        chk("edge8_lives", 80'(ifc.lives), 80'd3);
        set_reimu(313, 143);
        go_to(22);
        chk("hit1_hit", 80'(ifc.hit), 80'd1);
        chk("hit1_lives", 80'(ifc.lives), 80'd2);
        chk("hit1_v0", 80'(ifc.bullet_v[0]), 80'd0);
        chk("hit1_invuln", 80'(ifc.invuln), 80'd1);
        set_reimu(0, 0);
        go_to(23);
        chk("hit1_pulse", 80'(ifc.hit), 80'd0);
        go_to(33); set_reimu(340, 136);
        go_to(40);
        chk("inv_lives", 80'(ifc.lives), 80'd2);
        chk("inv_pass_v0", 80'(ifc.bullet_v[0]), 80'd1);
        go_to(80); set_reimu(0, 0); set_boss(292, 276);
        go_to(85);
        chk("inv_last", 80'(ifc.invuln), 80'd1);
        go_to(86);
        chk("inv_end", 80'(ifc.invuln), 80'd0);
        go_to(96); set_boss(228, 184);
        go_to(112); set_boss(320, 100);
        go_to(119); set_reimu(200, 200);
        go_to(120);
        chk("dbl_lives", 80'(ifc.lives), 80'd1);
        chk("dbl_hit", 80'(ifc.hit), 80'd1);
        chk("dbl_v", 80'(ifc.bullet_v), 80'h02);
        set_reimu(0, 0);
        go_to(192); set_reimu(320, 116);
        go_to(193);
        chk("go_lives", 80'(ifc.lives), 80'd0);
        chk("go_flag", 80'(ifc.gameover), 80'd1);
        go_to(200);
        #2;
        rst = 1'b0;
        #1;
        chk_reset("arst");
        @(posedge clk22);
        #1;
        set_reimu(0, 0);
        rst = 1'b1; e = 0;
        for (int k = 0; k < 11; k++) begin
            go_to(16 * k);
            set_boss(bxt[k], byt[k]);
        end
        go_to(176);
        chk("full_v", 80'(ifc.bullet_v), 80'hFF);
        set_boss(100, 200);
        go_to(192); set_boss(320, 200);
        go_to(193);
        chk("dirhold_x1", 80'(ifc.bullet_x[19:10]), 80'd104);
        chk("dirhold_y1", 80'(ifc.bullet_y[19:10]), 80'd216);
        go_to(207);
        chk("edge_x0", 80'(ifc.bullet_x[9:0]), 80'd636);
        chk("edge_v0", 80'(ifc.bullet_v[0]), 80'd1);
        go_to(208);
        chk("sametick_v", 80'(ifc.bullet_v), 80'hFE);
        chk("sametick_x2", 80'(ifc.bullet_x[29:20]), 80'd320);
        chk("sametick_y2", 80'(ifc.bullet_y[29:20]), 80'd216);
        go_to(224);
        chk("reuse_v0", 80'(ifc.bullet_v[0]), 80'd1);
        go_to(230);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
